unidade_controle_jogo: RTL and testbench
========================================

// Module: unidade_controle_jogo
// PURPOSE
// Control FSM for the sequence-memory game; drives every control input of the game datapath
// (address/round counters, play register, RAM write, timeout counters) and consumes its status.
// Each round the player repeats the stored sequence, then enters one new play, which is written to RAM.
// Sits directly above the datapath; top level wires it 1:1 to the datapath and the debug displays.
// PARAMETERS
// ESTADO_W     4     width of db_estado; must be >= 4
// PORTS
// clock                  in   1  system clock (1 kHz in the board build)
// reset                  in   1  asynchronous, active-high; forces INICIAL
// iniciar                in   1  start/restart request, level-sampled
// jogada_feita           in   1  1-cycle pulse: a button was pressed
// jogada_correta         in   1  registered play equals RAM[endereco]
// enderecoIgualRodada    in   1  address counter equals round counter
// fimCR                  in   1  round counter at 15 (last round)
// timeout                in   1  play-timeout counter reached its end
// timeout_jogada_inicial in   1  initial-display counter reached 2 s
// zeraR, registraR       out  1  play register clear / load
// zeraCR, contaCR        out  1  round counter clear / count
// zeraCE, contaCE        out  1  address counter clear / count
// zeraT, contaT          out  1  play-timeout counter clear / count
// zeraTI, contaTI        out  1  initial-display counter clear / count (contaTI also lights LEDs)
// grava                  out  1  RAM write enable (address = round counter)
// pronto, ganhou, perdeu out  1  game finished / won / lost
// db_estado              out  ESTADO_W  current state code
// BEHAVIOUR
// - Moore FSM; all outputs decoded from state only; state reg async-reset to INICIAL.
// - Reset value: every output 0, db_estado=0. Reset mid-game aborts immediately; no datapath clear
//   until PREPARACAO.
// - States (code: asserted outputs -> transition):
//   0 INICIAL: none -> iniciar ? PREPARACAO : stay
//   1 PREPARACAO: zeraR,zeraCR,zeraCE,zeraT,zeraTI -> MOSTRA_INICIAL
//   2 MOSTRA_INICIAL: contaTI -> timeout_jogada_inicial ? INICIO_RODADA : stay
//   3 INICIO_RODADA: zeraCE,zeraT -> ESPERA_JOGADA
//   4 ESPERA_JOGADA: contaT -> timeout ? FIM_TIMEOUT : jogada_feita ? REGISTRA : stay
//   5 REGISTRA: registraR,zeraT -> COMPARA
//   6 COMPARA: none -> !jogada_correta ? FIM_ERROU : !enderecoIgualRodada ? PROXIMA_JOGADA
//     : fimCR ? FIM_ACERTOU : ESPERA_NOVA
//   7 PROXIMA_JOGADA: contaCE -> ESPERA_JOGADA
//   8 ESPERA_NOVA: contaT -> timeout ? FIM_TIMEOUT : jogada_feita ? PROXIMA_RODADA : stay
//   9 PROXIMA_RODADA: contaCR,zeraT -> GRAVA_NOVA
//   A GRAVA_NOVA: grava -> INICIO_RODADA
//   B FIM_ACERTOU: pronto,ganhou; C FIM_ERROU: pronto,perdeu; D FIM_TIMEOUT: pronto,perdeu
//     all three -> iniciar ? PREPARACAO : stay
// - Unused codes E,F -> INICIAL next cycle, outputs 0.
// - Priority: timeout over jogada_feita when both are high in the same cycle.
// - Latency: grava is high exactly 2 cycles after the jogada_feita pulse; the buttons must still be
//   held (one 1 kHz press spans >> 2 cycles). New play lands at address rodada+1.
// - Comparison result is sampled 1 cycle after registraR (register output stable).
// - fimCR checked only after the full sequence of round 15 matches; no 17th play is recorded.
// - iniciar held high in INICIAL or FIM_* restarts the game; ignored in every other state.
// CONFIGURATION
// - JOGADA_TIMEOUT_EN defined: timeout honoured as above; contaT asserted in states 4 and 8.
// - Not defined: timeout input ignored, contaT tied 0, FIM_TIMEOUT unreachable (code D decodes
//   as unused -> INICIAL); states 4/8 wait indefinitely.
// TESTING
// - reset pulse mid-state 4 -> db_estado=0 same edge, all outputs 0.
// - iniciar=1, timeout_jogada_inicial after 5 cycles -> states 0,1,2x5,3,4; zeraTI=1 only in state 1.
// - Round 0: jogada_feita, jogada_correta=1, enderecoIgualRodada=1, fimCR=0 -> 5,6,8; next press
//   -> 9 (contaCR=1), A (grava=1, 2 cycles after pulse), 3.
// - Round 2, address 0: correct, enderecoIgualRodada=0 -> 6,7 (contaCE=1),4.
// - jogada_correta=0 in COMPARA -> C, pronto=1, perdeu=1; iniciar -> 1.
// - With JOGADA_TIMEOUT_EN: timeout and jogada_feita both high in state 4 -> D, perdeu=1;
//   without it: stays in 4 on timeout alone.
// - fimCR=1, last address matches -> B, ganhou=1, grava never asserted.

Source files
------------

// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore control FSM for the sequence-memory game (optional JOGADA_TIMEOUT_EN enables play timeout)
module unidade_controle_jogo #(
  parameter int ESTADO_W = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_iniciar,
  input  logic                i_jogada_feita,
  input  logic                i_jogada_correta,
  input  logic                i_enderecoIgualRodada,
  input  logic                i_fimCR,
  input  logic                i_timeout,
  input  logic                i_timeout_jogada_inicial,
  output logic                o_zeraR,
  output logic                o_registraR,
  output logic                o_zeraCR,
  output logic                o_contaCR,
  output logic                o_zeraCE,
  output logic                o_contaCE,
  output logic                o_zeraT,
  output logic                o_contaT,
  output logic                o_zeraTI,
  output logic                o_contaTI,
  output logic                o_grava,
  output logic                o_pronto,
  output logic                o_ganhou,
  output logic                o_perdeu,
  output logic [ESTADO_W-1:0] o_db_estado
);
`ifdef JOGADA_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    MOSTRA_INICIAL = 4'h2,
    INICIO_RODADA  = 4'h3,
    ESPERA_JOGADA  = 4'h4,
    REGISTRA       = 4'h5,
    COMPARA        = 4'h6,
    PROXIMA_JOGADA = 4'h7,
    ESPERA_NOVA    = 4'h8,
    PROXIMA_RODADA = 4'h9,
    GRAVA_NOVA     = 4'hA,
    FIM_ACERTOU    = 4'hB,
    FIM_ERROU      = 4'hC,
    FIM_TIMEOUT    = 4'hD
  } t_estado;
  t_estado r_estado, w_prox;
  logic    w_timeout;
  assign w_timeout   = i_timeout & TO_EN;
  assign o_db_estado = ESTADO_W'(r_estado);
  // state register; reset aborts any game immediately
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) r_estado <= INICIAL;
    else         r_estado <= w_prox;
  // next-state and Moore output decode; timeout has priority over a press
  always_comb begin
    w_prox      = r_estado;
    o_zeraR     = 1'b0;
    o_registraR = 1'b0;
    o_zeraCR    = 1'b0;
    o_contaCR   = 1'b0;
    o_zeraCE    = 1'b0;
    o_contaCE   = 1'b0;
    o_zeraT     = 1'b0;
    o_contaT    = 1'b0;
    o_zeraTI    = 1'b0;
    o_contaTI   = 1'b0;
    o_grava     = 1'b0;
    o_pronto    = 1'b0;
    o_ganhou    = 1'b0;
    o_perdeu    = 1'b0;
    case (r_estado)
      INICIAL:        w_prox = i_iniciar ? PREPARACAO : INICIAL;
      PREPARACAO: begin
        o_zeraR  = 1'b1;
        o_zeraCR = 1'b1;
        o_zeraCE = 1'b1;
        o_zeraT  = 1'b1;
        o_zeraTI = 1'b1;
        w_prox   = MOSTRA_INICIAL;
      end
      MOSTRA_INICIAL: begin
        o_contaTI = 1'b1;
        w_prox    = i_timeout_jogada_inicial ? INICIO_RODADA : MOSTRA_INICIAL;
      end
      INICIO_RODADA: begin
        o_zeraCE = 1'b1;
        o_zeraT  = 1'b1;
        w_prox   = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        o_contaT = TO_EN;
        w_prox   = w_timeout ? FIM_TIMEOUT : i_jogada_feita ? REGISTRA : ESPERA_JOGADA;
      end
      REGISTRA: begin
        o_registraR = 1'b1;
        o_zeraT     = 1'b1;
        w_prox      = COMPARA;
      end
      COMPARA:        w_prox = !i_jogada_correta ? FIM_ERROU :
                               !i_enderecoIgualRodada ? PROXIMA_JOGADA :
                               i_fimCR ? FIM_ACERTOU : ESPERA_NOVA;
      PROXIMA_JOGADA: begin
        o_contaCE = 1'b1;
        w_prox    = ESPERA_JOGADA;
      end
      ESPERA_NOVA: begin
        o_contaT = TO_EN;
        w_prox   = w_timeout ? FIM_TIMEOUT : i_jogada_feita ? PROXIMA_RODADA : ESPERA_NOVA;
      end
      PROXIMA_RODADA: begin
        o_contaCR = 1'b1;
        o_zeraT   = 1'b1;
        w_prox    = GRAVA_NOVA;
      end
      GRAVA_NOVA: begin
        o_grava = 1'b1;
        w_prox  = INICIO_RODADA;
      end
      FIM_ACERTOU: begin
        o_pronto = 1'b1;
        o_ganhou = 1'b1;
        w_prox   = i_iniciar ? PREPARACAO : FIM_ACERTOU;
      end
      FIM_ERROU: begin
        o_pronto = 1'b1;
        o_perdeu = 1'b1;
        w_prox   = i_iniciar ? PREPARACAO : FIM_ERROU;
      end
      FIM_TIMEOUT: begin
        o_pronto = TO_EN;
        o_perdeu = TO_EN;
        w_prox   = !TO_EN ? INICIAL : i_iniciar ? PREPARACAO : FIM_TIMEOUT;
      end
      default:        w_prox = INICIAL;
    endcase
  end
endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb_unidade_controle_jogo: randomized scoreboard bench for the game control FSM
module tb_unidade_controle_jogo;
`ifdef JOGADA_TIMEOUT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic iniciar = 0, jf = 0, jc = 0, eq = 0, fim = 0, to_in = 0, tji = 0;
  logic zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE, zeraT, contaT;
  logic zeraTI, contaTI, grava, pronto, ganhou, perdeu;
  logic [3:0] db_estado;
  int checks = 0, failures = 0;
  typedef struct packed {logic [3:0] st; logic [13:0] outs;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  unidade_controle_jogo #(.ESTADO_W(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_iniciar(iniciar), .i_jogada_feita(jf),
    .i_jogada_correta(jc), .i_enderecoIgualRodada(eq), .i_fimCR(fim),
    .i_timeout(to_in), .i_timeout_jogada_inicial(tji),
    .o_zeraR(zeraR), .o_registraR(registraR), .o_zeraCR(zeraCR), .o_contaCR(contaCR),
    .o_zeraCE(zeraCE), .o_contaCE(contaCE), .o_zeraT(zeraT), .o_contaT(contaT),
    .o_zeraTI(zeraTI), .o_contaTI(contaTI), .o_grava(grava), .o_pronto(pronto),
    .o_ganhou(ganhou), .o_perdeu(perdeu), .o_db_estado(db_estado)
  );
  localparam logic [13:0] ZR = 14'h2000, RR = 14'h1000, ZCR = 14'h0800, CCR = 14'h0400,
                          ZCE = 14'h0200, CCE = 14'h0100, ZT = 14'h0080, CT = 14'h0040,
                          ZTI = 14'h0020, CTI = 14'h0010, GR = 14'h0008, PR = 14'h0004,
                          GA = 14'h0002, PE = 14'h0001;
  function automatic logic [13:0] outs_of(input int s);
    case (s)
      1:  return ZR | ZCR | ZCE | ZT | ZTI;
      2:  return CTI;
      3:  return ZCE | ZT;
      4:  return EN ? CT : 14'h0;
      5:  return RR | ZT;
      7:  return CCE;
      8:  return EN ? CT : 14'h0;
      9:  return CCR | ZT;
      10: return GR;
      11: return PR | GA;
      12: return PR | PE;
      13: return EN ? (PR | PE) : 14'h0;
      default: return 14'h0;
    endcase
  endfunction
  function automatic int next_of(input int s);
    bit t;
    t = EN && to_in;
    case (s)
      0:  return iniciar ? 1 : 0;
      1:  return 2;
      2:  return tji ? 3 : 2;
      3:  return 4;
      4:  return t ? 13 : jf ? 5 : 4;
      5:  return 6;
      6:  return !jc ? 12 : !eq ? 7 : fim ? 11 : 8;
      7:  return 4;
      8:  return t ? 13 : jf ? 9 : 8;
      9:  return 10;
      10: return 3;
      11, 12: return iniciar ? 1 : s;
      13: return !EN ? 0 : iniciar ? 1 : s;
      default: return 0;
    endcase
  endfunction
  function automatic exp_t mk(input int s);
    exp_t e;
    e.st = 4'(s);
    e.outs = outs_of(s);
    return e;
  endfunction
  // monitor: every clock or reset edge produces a visible state to compare
  initial forever begin
    exp_t e;
    logic [13:0] got;
    @(posedge clk or posedge rst);
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE, zeraT, contaT,
             zeraTI, contaTI, grava, pronto, ganhou, perdeu};
      checks++;
      if (db_estado !== e.st || got !== e.outs) begin
        failures++;
        $display("FAIL state_outputs t=%0t: got st=%h outs=%b, expected st=%h outs=%b",
                 $time, db_estado, got, e.st, e.outs);
      end
    end
  end
  initial begin
    int m;
    bit did_rst4;
    m = 0;
    did_rst4 = 0;
    @(negedge clk);
    q.push_back(mk(0));
    rst = 1;
    q.push_back(mk(0));
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!rst && ((m == 4 && !did_rst4) || $urandom_range(0, 299) == 0)) begin
        if (m == 4) did_rst4 = 1;
        q.push_back(mk(0));
        rst = 1;
        m = 0;
        q.push_back(mk(0));
      end else begin
        rst = 0;
        iniciar = ($urandom_range(0, 3) == 0);
        jf      = ($urandom_range(0, 2) == 0);
        jc      = ($urandom_range(0, 7) != 0);
        eq      = ($urandom_range(0, 1) == 0);
        fim     = ($urandom_range(0, 5) == 0);
        to_in   = ($urandom_range(0, 9) == 0);
        tji     = ($urandom_range(0, 3) == 0);
        m = next_of(m);
        q.push_back(mk(m));
      end
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
